apu_audio_out: RTL



---
 rtl/apu_audio_out.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/apu_audio_out.sv
`default_nettype none
// ============================================================================
//  Module   : apu_audio_out
//  Purpose  : Stereo audio output stage for the APU. A zero-wait-state
//             AHB-Lite slave accepts packed 16-bit stereo samples into a
//             FIFO. A programmable divider pops one pair per sample period.
//             Each channel feeds a first-order sigma-delta modulator that
//             drives a 1-bit audio pin.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             ahbls_*               - AHB-Lite slave (haddr[3:2] decoded)
//             irq                   - FIFO-low interrupt (level)
//             audio_l, audio_r      - sigma-delta bitstreams
//  Revision : 1.0 - initial release
// ============================================================================
module apu_audio_out #(
    parameter int DEPTH  = 8,
    parameter int W_ADDR = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic [1:0]        ahbls_htrans,
    input  logic              ahbls_hwrite,
    input  logic [2:0]        ahbls_hsize,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    input  logic [31:0]       ahbls_hwdata,
    output logic [31:0]       ahbls_hrdata,
    output logic              irq,
    output logic              audio_l,
    output logic              audio_r
);

    localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_LVL = 4'(DEPTH);
    localparam logic [15:0] DIV_RST  = 16'h00ff;

    // Bus data-phase registers
    logic             dp_valid_q, dp_valid_d;
    logic             dp_write_q, dp_write_d;
    logic [1:0]       dp_addr_q,  dp_addr_d;
    // Control/status
    logic             en_q, en_d;
    logic             unf_q, unf_d;
    logic             ovf_q, ovf_d;
    logic             irq_en_q, irq_en_d;
    logic [3:0]       thresh_q, thresh_d;
    logic [15:0]      div_q, div_d;
    logic [15:0]      cnt_q, cnt_d;
    // FIFO bookkeeping
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]       level_q, level_d;
    logic [31:0]      fifo_mem_q [DEPTH];
    // Sample and modulator state
    logic [15:0]      samp_l_q, samp_l_d;
    logic [15:0]      samp_r_q, samp_r_d;
    logic [16:0]      acc_l_q, acc_l_d;
    logic [16:0]      acc_r_q, acc_r_d;
    logic             irq_q, irq_d;

    logic w_wr_csr, w_wr_fifo, w_wr_div;
    logic w_tick, w_pop_ok, w_push_ok, w_unf_set, w_ovf_set;
    logic [31:0] w_head;

    // Bits of the bus that carry no meaning for this slave
    logic unused_bus_bits;
    assign unused_bus_bits = ^{ahbls_hsize, ahbls_haddr[W_ADDR-1:4],
                               ahbls_haddr[1:0], ahbls_htrans[0]};

    assign ahbls_hready_resp = 1'b1;
    assign ahbls_hresp       = 1'b0;
    assign irq               = irq_q;
    assign audio_l           = acc_l_q[16];
    assign audio_r           = acc_r_q[16];
    assign w_head            = fifo_mem_q[rd_ptr_q];

    always_comb begin
        // Address phase capture
        dp_valid_d = ahbls_hready && ahbls_htrans[1];
        dp_write_d = ahbls_hwrite;
        dp_addr_d  = ahbls_haddr[3:2];

        w_wr_csr  = dp_valid_q && dp_write_q && (dp_addr_q == 2'd0);
        w_wr_fifo = dp_valid_q && dp_write_q && (dp_addr_q == 2'd1);
        w_wr_div  = dp_valid_q && dp_write_q && (dp_addr_q == 2'd2);

        // Sample tick and FIFO arbitration: a pop frees a slot for a
        // same-cycle push, so a full FIFO accepts the push when popping.
        w_tick    = en_q && (cnt_q == 16'd0);
        w_pop_ok  = w_tick && (level_q != 4'd0);
        w_unf_set = w_tick && (level_q == 4'd0);
        w_push_ok = w_wr_fifo && ((level_q != DEPTH_LVL) || w_pop_ok);
        w_ovf_set = w_wr_fifo && !w_push_ok;

        rd_ptr_d = w_pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = w_push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        case ({w_push_ok, w_pop_ok})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase

        // CSR: hardware set takes priority over a same-cycle w1c
        en_d     = w_wr_csr ? ahbls_hwdata[0]     : en_q;
        irq_en_d = w_wr_csr ? ahbls_hwdata[3]     : irq_en_q;
        thresh_d = w_wr_csr ? ahbls_hwdata[19:16] : thresh_q;
        unf_d    = (unf_q & ~(w_wr_csr & ahbls_hwdata[1])) | w_unf_set;
        ovf_d    = (ovf_q & ~(w_wr_csr & ahbls_hwdata[2])) | w_ovf_set;
        div_d    = w_wr_div ? ahbls_hwdata[15:0] : div_q;

        // Divider: held at DIV while disabled; new DIV only seen on reload
        if (!en_q || (cnt_q == 16'd0))
            cnt_d = div_q;
        else
            cnt_d = cnt_q - 16'd1;

        if (!en_q) begin
            samp_l_d = 16'd0;
            samp_r_d = 16'd0;
            acc_l_d  = 17'd0;
            acc_r_d  = 17'd0;
        end else begin
            samp_l_d = w_pop_ok ? w_head[15:0]  : samp_l_q;
            samp_r_d = w_pop_ok ? w_head[31:16] : samp_r_q;
            // Offset-binary input; carry out of the 16-bit sum is the bit
            acc_l_d  = {1'b0, acc_l_q[15:0]} + {1'b0, samp_l_q ^ 16'h8000};
            acc_r_d  = {1'b0, acc_r_q[15:0]} + {1'b0, samp_r_q ^ 16'h8000};
        end

        irq_d = en_q && irq_en_q && (level_q <= thresh_q);
    end

    // Read data is driven straight from state during a read data phase
    always_comb begin
        ahbls_hrdata = 32'd0;
        if (dp_valid_q && !dp_write_q) begin
            case (dp_addr_q)
                2'd0:    ahbls_hrdata = {12'd0, thresh_q, 4'd0, level_q,
                                         4'd0, irq_en_q, ovf_q, unf_q, en_q};
                2'd2:    ahbls_hrdata = {16'd0, div_q};
                default: ahbls_hrdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 2'd0;
            en_q       <= 1'b0;
            unf_q      <= 1'b0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            thresh_q   <= 4'd0;
            div_q      <= DIV_RST;
            cnt_q      <= DIV_RST;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= 4'd0;
            samp_l_q   <= 16'd0;
            samp_r_q   <= 16'd0;
            acc_l_q    <= 17'd0;
            acc_r_q    <= 17'd0;
            irq_q      <= 1'b0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            en_q       <= en_d;
            unf_q      <= unf_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            samp_l_q   <= samp_l_d;
            samp_r_q   <= samp_r_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            irq_q      <= irq_d;
        end
    end

    // Storage needs no reset: the pointers and level define its contents
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok)
            fifo_mem_q[wr_ptr_q] <= ahbls_hwdata;
    end

endmodule
`default_nettype wire
